// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side control logic.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        GUARD
    } ctrl_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a level count and a
// one-cycle flush. Also used on the TX side, so it knows nothing about UARTs.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Flush takes priority: anything pushed or popped in the flush cycle is discarded.
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    assign empty    = (level == '0);
    assign full     = (level == LW'(DEPTH));
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset; the read port is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Drains the UART receiver holding byte into a local FIFO, tracks receiver
// errors and raises a level/timeout/error interrupt for the host.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int THRESH  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         flush,
    input  logic [UART_DATA_W-1:0]       rx_data,
    input  logic                         rx_data_valid,
    input  logic                         framing_err,
    input  logic                         overrun,
    output logic                         host_ready,
    output logic                         clear_framing_err,
    input  logic                         rd_en,
    output logic [UART_DATA_W-1:0]       rd_data,
    output logic                         rd_valid,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic [CNT_W-1:0]             ferr_cnt,
    output logic [CNT_W-1:0]             ovr_cnt,
    input  logic                         clr_cnt,
    output logic                         irq
);

    localparam int LVL_W = $clog2(DEPTH+1);
    localparam int TMO_W = $clog2(TIMEOUT+1);

    ctrl_state_e      state;
    ctrl_state_e      state_next;
    logic             fifo_push;
    logic             fifo_empty;
    logic             fifo_full;
    logic             push_evt;
    logic             pop_evt;
    logic             ferr_armed;
    logic             ferr_hit;
    logic             ovr_q;
    logic             ovr_rise;
    logic             err_pending;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hold;
    logic             timeout_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    // GUARD forces a gap after every accept so host_ready never fires twice in a row.
    always_comb begin
        state_next = state;
        host_ready = 1'b0;
        fifo_push  = 1'b0;
        case (state)
            IDLE: begin
                if (enable && rx_data_valid && !fifo_full)
                    state_next = ACCEPT;
            end
            ACCEPT: begin
                host_ready = 1'b1;
                fifo_push  = 1'b1;
                state_next = GUARD;
            end
            GUARD: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .push      (fifo_push),
        .push_data (rx_data),
        .pop       (rd_en),
        .pop_data  (rd_data),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (level)
    );

    assign rd_valid = ~fifo_empty;
    assign push_evt = fifo_push & ~flush;
    assign pop_evt  = rd_en & rd_valid & ~flush;

    // ferr_armed remembers that framing_err was last seen low, so a held error counts once.
    assign ferr_hit = framing_err & ferr_armed;
    assign ovr_rise = overrun & ~ovr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ferr_armed        <= 1'b1;
            ovr_q             <= 1'b0;
            clear_framing_err <= 1'b0;
            ferr_cnt          <= '0;
            ovr_cnt           <= '0;
            err_pending       <= 1'b0;
        end else begin
            ferr_armed        <= ~framing_err;
            ovr_q             <= overrun;
            clear_framing_err <= ferr_hit;
            if (clr_cnt) begin
                ferr_cnt    <= '0;
                ovr_cnt     <= '0;
                err_pending <= 1'b0;
            end else begin
                if (ferr_hit && (ferr_cnt != '1))
                    ferr_cnt <= ferr_cnt + 1'b1;
                if (ovr_rise && (ovr_cnt != '1))
                    ovr_cnt <= ovr_cnt + 1'b1;
                if (ferr_hit || ovr_rise)
                    err_pending <= 1'b1;
            end
        end
    end

    // The flag rises on the cycle the counter reaches TIMEOUT; it then sits saturated.
    assign tmo_hold = push_evt | flush | (level == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (tmo_hold)
                tmo_cnt <= '0;
            else if (tmo_cnt != TMO_W'(TIMEOUT))
                tmo_cnt <= tmo_cnt + 1'b1;

            if (flush || pop_evt)
                timeout_flag <= 1'b0;
            else if (!tmo_hold && (tmo_cnt == TMO_W'(TIMEOUT - 1)))
                timeout_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq <= 1'b0;
        else
            irq <= (level >= LVL_W'(THRESH)) | timeout_flag | err_pending;
    end

endmodule
